// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the exception scheduler: exception codes,
// the exception vector and the scheduler FSM state type.
package cp0_pkg;

   localparam logic [4:0]  ExcCodeInt = 5'h00;
   localparam logic [4:0]  ExcCodeSys = 5'h08;
   localparam logic [4:0]  ExcCodeRi  = 5'h0A;
   localparam logic [4:0]  ExcCodeOv  = 5'h0C;

   localparam logic [31:0] ExcVector  = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      StIdle,
      StCommit,
      StFlush
   } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selector for pending exception/eret requests:
// interrupt > overflow > reserved instruction > syscall > eret.
module exc_prio_enc
   import cp0_pkg::*;
(
   input  logic       int_hit_i,
   input  logic       ovf_i,
   input  logic       ri_i,
   input  logic       sys_i,
   input  logic       eret_i,
   output logic       valid_o,
   output logic       eret_o,
   output logic       exe_pc_o,
   output logic [4:0] code_o
);

   always_comb begin
      valid_o  = 1'b1;
      eret_o   = 1'b0;
      exe_pc_o = 1'b0;
      code_o   = 5'h00;
      if (int_hit_i) begin
         code_o = ExcCodeInt;
      end else if (ovf_i) begin
         code_o   = ExcCodeOv;
         exe_pc_o = 1'b1;
      end else if (ri_i) begin
         code_o = ExcCodeRi;
      end else if (sys_i) begin
         code_o = ExcCodeSys;
      end else if (eret_i) begin
         eret_o = 1'b1;
      end else begin
         valid_o = 1'b0;
      end
   end

endmodule

// File: rtl/exc_sched.sv
// CP0 exception scheduler: IDLE -> COMMIT -> FLUSH sequencer driving CP0 writes,
// PC redirect and pipeline flushes. Interrupts enabled by macro EXC_SCHED_INT_EN.
module exc_sched
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        exe_ovf,
   input  logic [31:0] exe_pc,
   input  logic        id_ri,
   input  logic        id_sys,
   input  logic        id_eret,
   input  logic [31:0] id_pc,
   input  logic [5:0]  int_req,
   input  logic [31:0] status_in,
   input  logic [31:0] epc_in,
   output logic        we_epc,
   output logic        we_cause,
   output logic        we_status,
   output logic [31:0] epc_wdata,
   output logic [4:0]  exc_code,
   output logic [31:0] status_wdata,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        if_flush,
   output logic        id_flush,
   output logic        exe_flush,
   output logic        busy,
   output logic [7:0]  exc_cnt
);

   exc_state_e  state_q, state_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] epc_q, epc_d;
   logic        eret_q, eret_d;
   logic        exl_q, exl_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        int_hit;
   logic        sel_valid, sel_eret, sel_exe_pc;
   logic [4:0]  sel_code;

`ifdef EXC_SCHED_INT_EN
   assign int_hit = status_in[0] & ~status_in[1] & (|(int_req & status_in[15:10]));
`else
   logic unused_int_req;
   assign unused_int_req = ^int_req;
   assign int_hit        = 1'b0;
`endif

   exc_prio_enc u_prio (
      .int_hit_i (int_hit),
      .ovf_i     (exe_ovf),
      .ri_i      (id_ri),
      .sys_i     (id_sys),
      .eret_i    (id_eret),
      .valid_o   (sel_valid),
      .eret_o    (sel_eret),
      .exe_pc_o  (sel_exe_pc),
      .code_o    (sel_code)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         code_q  <= 5'h00;
         epc_q   <= 32'h0;
         eret_q  <= 1'b0;
         exl_q   <= 1'b0;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         epc_q   <= epc_d;
         eret_q  <= eret_d;
         exl_q   <= exl_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      epc_d   = epc_q;
      eret_d  = eret_q;
      exl_d   = exl_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (sel_valid) begin
               state_d = StCommit;
               code_d  = sel_code;
               eret_d  = sel_eret;
               exl_d   = status_in[1];
               // eret reuses the EPC latch to hold its return target
               epc_d   = sel_eret ? epc_in : (sel_exe_pc ? exe_pc : id_pc);
            end
         end
         StCommit: begin
            state_d = StFlush;
            if (!eret_q) cnt_d = cnt_q + 8'd1;
         end
         StFlush:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are forced to zero while reset is asserted so no strobe leaks on that cycle.
   always_comb begin
      we_epc       = 1'b0;
      we_cause     = 1'b0;
      we_status    = 1'b0;
      epc_wdata    = 32'h0;
      exc_code     = 5'h00;
      status_wdata = 32'h0;
      redirect     = 1'b0;
      redirect_pc  = 32'h0;
      if_flush     = 1'b0;
      id_flush     = 1'b0;
      exe_flush    = 1'b0;
      busy         = 1'b0;
      exc_cnt      = 8'h00;
      if (reset) begin
         exc_cnt = cnt_q;
         if (state_q == StCommit) begin
            busy      = 1'b1;
            we_status = 1'b1;
            if (eret_q) begin
               status_wdata = status_in & 32'hFFFF_FFFD;
            end else begin
               status_wdata = status_in | 32'h0000_0002;
               we_cause     = 1'b1;
               exc_code     = code_q;
               if (!exl_q) begin
                  we_epc    = 1'b1;
                  epc_wdata = epc_q;
               end
            end
         end else if (state_q == StFlush) begin
            busy        = 1'b1;
            redirect    = 1'b1;
            redirect_pc = eret_q ? epc_q : ExcVector;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            exe_flush   = ~eret_q;
         end
      end
   end

endmodule

// File: tb/tb_exc_sched.sv
// Randomized self-checking bench for exc_sched against a phase-based reference model,
// plus directed scenarios for the documented corner cases.
module tb_exc_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        exe_ovf, id_ri, id_sys, id_eret;
   logic [31:0] exe_pc, id_pc, status_in, epc_in;
   logic [5:0]  int_req;
   logic        we_epc, we_cause, we_status, redirect, if_flush, id_flush, exe_flush, busy;
   logic [31:0] epc_wdata, status_wdata, redirect_pc;
   logic [4:0]  exc_code;
   logic [7:0]  exc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: phase 0 idle, 1 commit, 2 flush
   int          m_phase = 0;
   bit          m_eret;
   bit [4:0]    m_code;
   bit [31:0]   m_epc;
   bit          m_exl;
   int          m_cnt = 0;

   always #5 clk = ~clk;

   exc_sched dut (
      .clk          (clk),
      .reset        (reset),
      .exe_ovf      (exe_ovf),
      .exe_pc       (exe_pc),
      .id_ri        (id_ri),
      .id_sys       (id_sys),
      .id_eret      (id_eret),
      .id_pc        (id_pc),
      .int_req      (int_req),
      .status_in    (status_in),
      .epc_in       (epc_in),
      .we_epc       (we_epc),
      .we_cause     (we_cause),
      .we_status    (we_status),
      .epc_wdata    (epc_wdata),
      .exc_code     (exc_code),
      .status_wdata (status_wdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .if_flush     (if_flush),
      .id_flush     (id_flush),
      .exe_flush    (exe_flush),
      .busy         (busy),
      .exc_cnt      (exc_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit        e_we_epc = 0, e_we_cause = 0, e_we_status = 0, e_redirect = 0;
      bit        e_flush_fe = 0, e_exe_flush = 0, e_busy = 0;
      bit [31:0] e_epc = 0, e_status = 0, e_rpc = 0;
      bit [4:0]  e_code = 0;
      bit [7:0]  e_cnt = 0;
      if (reset) begin
         e_cnt = 8'(m_cnt);
         if (m_phase == 1) begin
            e_busy      = 1;
            e_we_status = 1;
            if (m_eret) begin
               e_status = status_in & ~32'd2;
            end else begin
               e_status   = status_in | 32'd2;
               e_we_cause = 1;
               e_code     = m_code;
               e_we_epc   = !m_exl;
               e_epc      = m_exl ? 32'd0 : m_epc;
            end
         end else if (m_phase == 2) begin
            e_busy      = 1;
            e_redirect  = 1;
            e_flush_fe  = 1;
            e_exe_flush = !m_eret;
            e_rpc       = m_eret ? m_epc : 32'hBFC0_0380;
         end
      end
      check_eq("we_epc", we_epc, e_we_epc);
      check_eq("we_cause", we_cause, e_we_cause);
      check_eq("we_status", we_status, e_we_status);
      check_eq("epc_wdata", epc_wdata, e_epc);
      check_eq("exc_code", exc_code, e_code);
      check_eq("status_wdata", status_wdata, e_status);
      check_eq("redirect", redirect, e_redirect);
      check_eq("redirect_pc", redirect_pc, e_rpc);
      check_eq("if_flush", if_flush, e_flush_fe);
      check_eq("id_flush", id_flush, e_flush_fe);
      check_eq("exe_flush", exe_flush, e_exe_flush);
      check_eq("busy", busy, e_busy);
      check_eq("exc_cnt", exc_cnt, e_cnt);
   endtask

   task automatic model_edge();
      bit int_hit = 0;
`ifdef EXC_SCHED_INT_EN
      int_hit = status_in[0] && !status_in[1] && ((int_req & status_in[15:10]) != 0);
`endif
      if (!reset) begin
         m_phase = 0;
         m_cnt   = 0;
      end else if (m_phase == 0) begin
         m_exl  = status_in[1];
         m_eret = 0;
         m_phase = 1;
         if (int_hit) begin
            m_code = 5'h00; m_epc = id_pc;
         end else if (exe_ovf) begin
            m_code = 5'h0C; m_epc = exe_pc;
         end else if (id_ri) begin
            m_code = 5'h0A; m_epc = id_pc;
         end else if (id_sys) begin
            m_code = 5'h08; m_epc = id_pc;
         end else if (id_eret) begin
            m_eret = 1; m_epc = epc_in;
         end else begin
            m_phase = 0;
         end
      end else if (m_phase == 1) begin
         if (!m_eret) m_cnt = (m_cnt + 1) % 256;
         m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   // inputs are set at posedge+1; outputs checked at posedge+3
   task automatic tick();
      #2;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      exe_ovf = 0; id_ri = 0; id_sys = 0; id_eret = 0; int_req = 0;
      exe_pc = 32'h0040_0000; id_pc = 32'h0040_0004; epc_in = 32'h0; status_in = 32'h0;
   endtask

   initial begin
      reset = 0;
      idle_inputs();
      @(posedge clk); #1;
      tick();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_cnt", exc_cnt, 8'h00);
      reset = 1;
      tick();

      // overflow with EXL=0
      exe_ovf = 1; exe_pc = 32'h0040_0010;
      tick();
      idle_inputs();
      #1;
      check_eq("ovf_we_epc", we_epc, 1'b1);
      check_eq("ovf_epc", epc_wdata, 32'h0040_0010);
      check_eq("ovf_code", exc_code, 5'h0C);
      tick();
      #1;
      check_eq("ovf_vec", redirect_pc, 32'hBFC0_0380);
      check_eq("ovf_exe_flush", exe_flush, 1'b1);
      tick();
      tick();

      // overflow beats syscall
      exe_ovf = 1; id_sys = 1;
      tick();
      idle_inputs();
      #1;
      check_eq("prio_code", exc_code, 5'h0C);
      tick();
      tick();
      check_eq("prio_cnt", exc_cnt, 8'd2);

      // eret
      id_eret = 1; epc_in = 32'h0040_0020; status_in = 32'h0000_0003;
      tick();
      idle_inputs(); status_in = 32'h0000_0003;
      #1;
      check_eq("eret_exl", status_wdata[1], 1'b0);
      check_eq("eret_we_epc", we_epc, 1'b0);
      tick();
      #1;
      check_eq("eret_rpc", redirect_pc, 32'h0040_0020);
      check_eq("eret_exe_flush", exe_flush, 1'b0);
      tick();

      // RI with EXL=1, then masked interrupt with EXL=1
      id_ri = 1; status_in = 32'h0000_0002;
      tick();
      idle_inputs(); status_in = 32'h0000_0002;
      #1;
      check_eq("ri_we_epc", we_epc, 1'b0);
      check_eq("ri_code", exc_code, 5'h0A);
      tick();
      tick();
      int_req = 6'h01; status_in = 32'h0000_0403;
      tick();
      idle_inputs();
      #1;
      check_eq("int_exl_busy", busy, 1'b0);
      tick();

      // reset during COMMIT
      exe_ovf = 1;
      tick();
      idle_inputs(); reset = 0;
      tick();
      reset = 1;
      #1;
      check_eq("rst_commit_busy", busy, 1'b0);
      check_eq("rst_commit_redir", redirect, 1'b0);
      tick();

      // counter wrap: 256 overflows from a fresh reset
      reset = 0; tick(); reset = 1;
      for (int i = 0; i < 256; i++) begin
         exe_ovf = 1; exe_pc = 32'(i);
         tick();
         idle_inputs();
         tick();
         tick();
         if (i == 254) check_eq("cnt_255", exc_cnt, 8'd255);
      end
      check_eq("cnt_wrap", exc_cnt, 8'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 59) != 0);
         exe_ovf   = ($urandom_range(0, 5) == 0);
         id_ri     = ($urandom_range(0, 5) == 0);
         id_sys    = ($urandom_range(0, 5) == 0);
         id_eret   = ($urandom_range(0, 4) == 0);
         int_req   = 6'($urandom);
         exe_pc    = $urandom;
         id_pc     = $urandom;
         epc_in    = $urandom;
         status_in = $urandom;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_sched.md
EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock
- reset, in, 1, synchronous, active-low
- exe_ovf, in, 1, arithmetic overflow in EXE
- exe_pc, in, 32, PC of the EXE instruction
- id_ri, in, 1, reserved instruction in ID
- id_sys, in, 1, syscall in ID
- id_eret, in, 1, eret in ID
- id_pc, in, 32, PC of the ID instruction
- int_req, in, 6, hardware interrupt lines
- status_in, in, 32, current Status (bit0 IE, bit1 EXL, bits15:10 IM)
- epc_in, in, 32, current EPC
- we_epc / we_cause / we_status, out, 1 each, CP0 write strobes
- epc_wdata, out, 32, value for EPC
- exc_code, out, 5, value for Cause[6:2]
- status_wdata, out, 32, value for Status
- redirect, out, 1, PC redirect valid
- redirect_pc, out, 32, redirect target
- if_flush / id_flush / exe_flush, out, 1 each, pipeline flush strobes
- busy, out, 1, scheduler sequencing (stall the pipeline)
- exc_cnt, out, 8, taken-exception counter

Function
REQ-002 SHALL use a three-state FSM: IDLE -> COMMIT -> FLUSH -> IDLE.
REQ-003 SHALL sample requests only in IDLE; all requests are ignored while busy=1.
REQ-004 SHALL use fixed priority: interrupt > exe_ovf > id_ri > id_sys > id_eret.
REQ-005 SHALL raise an interrupt only when IE=1, EXL=0 and (int_req & IM) != 0.
REQ-006 SHALL latch code and EPC in IDLE on a winning request, then go to COMMIT next cycle:
- interrupt: code 0x00, EPC id_pc
- overflow: code 0x0C, EPC exe_pc
- RI: code 0x0A, EPC id_pc
- syscall: code 0x08, EPC id_pc
REQ-007 SHALL, in COMMIT for an exception, pulse we_cause and we_status for one cycle.
- status_wdata is status_in with bit1 set.
- we_epc pulses only if the latched EXL was 0.
REQ-008 SHALL, in FLUSH for an exception, pulse redirect with redirect_pc = 32'hBFC00380 and all three flushes for one cycle.
REQ-009 SHALL treat an eret winner as follows:
- COMMIT: we_status with bit1 cleared; no EPC or Cause write.
- FLUSH: redirect_pc = latched epc_in, if_flush and id_flush asserted, exe_flush low.
REQ-010 SHALL hold busy=1 in COMMIT and FLUSH; request-to-redirect latency is exactly 2 cycles.
REQ-011 SHALL increment exc_cnt once per exception (not eret) in COMMIT, wrapping 255 -> 0.
REQ-012 SHALL resolve simultaneous requests by REQ-004 alone; losers are dropped, not queued.
REQ-013 SHALL drive every strobe low in IDLE and every data output to 0 when its strobe is low.

Reset
REQ-014 SHALL, on reset=0 at a clk edge, enter IDLE from any state and abandon any latched request.
REQ-015 SHALL reset exc_cnt, latches and all outputs to 0, with no strobe pulse on the reset cycle.

Configuration
REQ-016 SHALL support macro EXC_SCHED_INT_EN.
- Defined: interrupts per REQ-005.
- Undefined: int_req is ignored, code 0x00 is never produced, and the int_req port remains.

Structure
REQ-017 SHALL place exception codes, the 32'hBFC00380 vector and the FSM state typedef in shared package cp0_pkg.
REQ-018 SHALL implement priority selection in one combinational sub-module, exc_prio_enc.

Verification
REQ-019 exe_ovf=1, exe_pc=0x400010, EXL=0 -> next cycle we_epc/we_cause/we_status=1, epc_wdata=0x400010, exc_code=0x0C; following cycle redirect_pc=0xBFC00380, three flushes=1.
REQ-020 exe_ovf=1 and id_sys=1 in the same cycle -> only code 0x0C is committed, and exc_cnt increments by 1.
REQ-021 id_eret=1 with epc_in=0x400020 -> status_wdata bit1=0 with no we_epc; next cycle redirect_pc=0x400020, exe_flush=0.
REQ-022 id_ri=1 with status_in EXL=1 -> we_epc=0, exc_code=0x0A; int_req=6'h01 with IM=0x01, IE=1, EXL=1 -> no action.
REQ-023 reset=0 during COMMIT -> next cycle IDLE, all outputs 0, no redirect.
REQ-024 256 overflow exceptions -> exc_cnt returns to 0.
